// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single fixed-latency data memory.
// The CPU port (c_*) and the loader port (l_*) compete for one memory port; each
// granted access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE, then the
// other port is favoured on the next tie.
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  // CPU port
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_done,
  output logic [DW-1:0] c_rdata,
  // Loader port
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_done,
  output logic [DW-1:0] l_rdata,
  // Memory port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Owner encoding: 0 = CPU, 1 = loader.
  localparam logic OWN_CPU    = 1'b0;
  localparam logic OWN_LOADER = 1'b1;

  state_t     state;
  logic       owner;
  logic       last_owner;
  logic       we_q;
  logic [3:0] cnt;
  logic       any_req;
  logic       winner;

  // Pick the winner: a lone requester wins, a tie goes to whoever did not own last.
  // NOTE: every signal written here gets a value on every path so no latch is inferred.
  always_comb begin
    any_req = c_req | l_req;
    winner  = OWN_CPU;
    if (c_req && l_req) begin
      winner = ~last_owner;
    end else if (l_req) begin
      winner = OWN_LOADER;
    end
  end

  // Grants exist only in IDLE and are forced low while reset is held.
  assign c_gnt = reset && (state == IDLE) && any_req && (winner == OWN_CPU);
  assign l_gnt = reset && (state == IDLE) && any_req && (winner == OWN_LOADER);

  // Access sequencer with registered memory strobes, done pulses and read data.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_LOADER;
      we_q       <= 1'b0;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      c_done     <= 1'b0;
      l_done     <= 1'b0;
      busy       <= 1'b0;
      // NOTE: the read-data holding registers are reset too, since every output reads 0 in reset.
      c_rdata    <= '0;
      l_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= winner;
            we_q      <= (winner == OWN_LOADER) ? l_we : c_we;
            mem_en    <= 1'b1;
            mem_we    <= (winner == OWN_LOADER) ? l_we : c_we;
            mem_addr  <= (winner == OWN_LOADER) ? l_addr : c_addr;
            mem_wdata <= (winner == OWN_LOADER) ? l_wdata : c_wdata;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // The strobe lasts exactly one cycle; the bus returns to zero behind it.
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          cnt       <= 4'(MEM_LAT - 1);
          state     <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (!we_q) begin
              if (owner == OWN_LOADER) l_rdata <= mem_rdata;
              else                     c_rdata <= mem_rdata;
            end
            c_done <= (owner == OWN_CPU);
            l_done <= (owner == OWN_LOADER);
            state  <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          c_done     <= 1'b0;
          l_done     <= 1'b0;
          last_owner <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MEM_LAT=1 backed by a small
// word memory, one at MEM_LAT=3 with a constant read bus for the reset-abort case.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  // MEM_LAT = 1 instance signals
  logic        reset;
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_gnt, c_done, l_gnt, l_done;
  logic [31:0] c_rdata, l_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // MEM_LAT = 3 instance signals
  logic        s_reset;
  logic        s_c_req;
  logic [31:0] s_c_addr;
  logic        s_c_gnt, s_c_done, s_l_gnt, s_l_done;
  logic [31:0] s_c_rdata, s_l_rdata;
  logic        s_mem_en, s_mem_we, s_busy;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [31:0] s_mem_rdata = 32'hCAFE_F00D;

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
    .clock(clock), .reset(s_reset),
    .c_req(s_c_req), .c_we(1'b0), .c_addr(s_c_addr), .c_wdata(32'h0),
    .c_gnt(s_c_gnt), .c_done(s_c_done), .c_rdata(s_c_rdata),
    .l_req(1'b0), .l_we(1'b0), .l_addr(32'h0), .l_wdata(32'h0),
    .l_gnt(s_l_gnt), .l_done(s_l_done), .l_rdata(s_l_rdata),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(s_mem_rdata), .busy(s_busy)
  );

  // Word memory with one cycle of read latency.
  logic [31:0] mem [0:63];
  initial mem_rdata = 32'h0;
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:2]];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Event log, sampled mid-cycle after the stimulus has settled.
  int cg_q[$], lg_q[$], cd_q[$], ld_q[$];
  int both_cnt   = 0;
  int s_done_cnt = 0;
  int s_ldone_cnt = 0;
  always @(negedge clock) begin
    #2;
    if (c_gnt)  cg_q.push_back(cyc);
    if (l_gnt)  lg_q.push_back(cyc);
    if (c_done) cd_q.push_back(cyc);
    if (l_done) ld_q.push_back(cyc);
    if (c_gnt && l_gnt) both_cnt++;
    if (s_c_gnt && s_l_gnt) both_cnt++;
    if (s_c_done) s_done_cnt++;
    if (s_l_done) s_ldone_cnt++;
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  int t0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[32'h08 >> 2] = 32'h0000_0088;
    mem[32'h0C >> 2] = 32'h0000_00CC;
    mem[32'h10 >> 2] = 32'hDEAD_BEEF;
    mem[32'h20 >> 2] = 32'h0000_0055;
    mem[32'h30 >> 2] = 32'h0000_0033;

    reset = 1'b0; s_reset = 1'b0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    s_c_req = 0; s_c_addr = 0;

    // Reset values, with a request pending to prove grants stay low in reset.
    tick(2);
    c_req = 1; #1;
    check("rst_c_gnt", c_gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_dones", {c_done, l_done}, 0);
    check("rst_rdata", c_rdata | l_rdata, 0);
    c_req = 0;
    tick(1);
    reset = 1'b1; s_reset = 1'b1;

    // Both ports hold requests from the first access after reset.
    tick(1);
    cg_q.delete(); lg_q.delete(); cd_q.delete(); ld_q.delete();
    tick(1);
    t0 = cyc;
    c_req = 1; c_we = 0; c_addr = 32'h30;
    l_req = 1; l_we = 0; l_addr = 32'h20;
    #1;
    check("t2_first_c_gnt", c_gnt, 1);
    check("t2_first_l_gnt", l_gnt, 0);
    tick(21);
    c_req = 0; l_req = 0;
    tick(4);
    #3;
    check("t3_c_gnt_count", cg_q.size(), 3);
    check("t3_l_gnt_count", lg_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_c_gnt%0d", i), cg_q[i] - t0, i * 8);
      check($sformatf("t3_l_gnt%0d", i), lg_q[i] - t0, i * 8 + 4);
    end
    check("t2_c_done_at", cd_q[0] - t0, 3);
    check("t2_l_done_at", ld_q[0] - t0, 7);
    check("t3_l_done_last", ld_q[2] - t0, 23);
    check("t3_c_rdata", c_rdata, 32'h0000_0033);
    check("t3_l_rdata", l_rdata, 32'h0000_0055);

    // CPU read at MEM_LAT=1, cycle by cycle.
    tick(1);
    c_req = 1; c_we = 0; c_addr = 32'h10; #1;
    check("t1_gnt", c_gnt, 1);
    check("t1_busy_idle", busy, 0);
    tick(1);
    c_req = 0; #1;
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_mem_we", mem_we, 0);
    check("t1_no_gnt_issue", c_gnt, 0);
    tick(1); #1;
    check("t1_mem_en_off", mem_en, 0);
    check("t1_mem_addr_off", mem_addr, 0);
    check("t1_done_early", c_done, 0);
    tick(1); #1;
    check("t1_done", c_done, 1);
    check("t1_rdata", c_rdata, 32'hDEAD_BEEF);
    check("t1_busy_done", busy, 1);
    tick(1); #1;
    check("t1_done_pulse", c_done, 0);
    check("t1_busy_end", busy, 0);

    // Loader write followed by a CPU read of the same address.
    l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'h1234; #1;
    check("t4_l_gnt", l_gnt, 1);
    check("t4_c_gnt", c_gnt, 0);
    tick(1);
    l_req = 0; l_we = 0; l_wdata = 0; #1;
    check("t4_w_mem_en", mem_en, 1);
    check("t4_w_mem_we", mem_we, 1);
    check("t4_w_addr", mem_addr, 32'h40);
    check("t4_w_wdata", mem_wdata, 32'h1234);
    tick(1); #1;
    check("t4_w_we_off", mem_we, 0);
    check("t4_w_wdata_off", mem_wdata, 0);
    tick(1); #1;
    check("t4_l_done", l_done, 1);
    check("t4_l_rdata_kept", l_rdata, 32'h55);
    tick(1);
    c_req = 1; c_we = 0; c_addr = 32'h40; #1;
    check("t4_c_gnt", c_gnt, 1);
    tick(1);
    c_req = 0; #1;
    check("t4_r_mem_en", mem_en, 1);
    check("t4_r_mem_we", mem_we, 0);
    tick(2); #1;
    check("t4_c_done", c_done, 1);
    check("t4_c_rdata", c_rdata, 32'h1234);
    check("t4_l_rdata", l_rdata, 32'h55);

    // Address changes after grant do not disturb the access in flight.
    tick(1);
    c_req = 1; c_addr = 32'h8; #1;
    check("t6_gnt", c_gnt, 1);
    tick(1);
    c_addr = 32'hC; #1;
    check("t6_mem_addr", mem_addr, 32'h8);
    check("t6_no_gnt_busy", c_gnt, 0);
    tick(2); #1;
    check("t6_done1", c_done, 1);
    check("t6_rdata1", c_rdata, 32'h88);
    check("t6_no_gnt_done", c_gnt, 0);
    tick(1); #1;
    check("t6_regnt", c_gnt, 1);
    tick(1);
    c_req = 0; #1;
    check("t6_mem_addr2", mem_addr, 32'hC);
    tick(2); #1;
    check("t6_done2", c_done, 1);
    check("t6_rdata2", c_rdata, 32'hCC);

    // MEM_LAT=3: reset during WAIT aborts, then a fresh read takes 6 cycles.
    tick(1);
    s_c_req = 1; s_c_addr = 32'h4; #1;
    check("t5_gnt", s_c_gnt, 1);
    tick(1);
    s_c_req = 0; #1;
    check("t5_mem_en", s_mem_en, 1);
    check("t5_mem_addr", s_mem_addr, 32'h4);
    tick(1);
    s_reset = 1'b0; #1;
    check("t5_rst_busy", s_busy, 0);
    check("t5_rst_mem", {s_mem_en, s_mem_we, s_mem_addr | s_mem_wdata}, 0);
    check("t5_rst_done", s_c_done, 0);
    check("t5_rst_rdata", s_c_rdata, 0);
    tick(4);
    s_reset = 1'b1;
    tick(2);
    check("t5_abort_no_done", s_done_cnt, 0);
    s_c_req = 1; s_c_addr = 32'h4; #1;
    check("t5_fresh_gnt", s_c_gnt, 1);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      s_c_req = 0; #1;
      check($sformatf("t5_done_c%0d", k), s_c_done, (k == 5) ? 32'd1 : 32'd0);
    end
    check("t5_rdata", s_c_rdata, 32'hCAFE_F00D);
    check("t5_l_rdata", s_l_rdata, 0);
    tick(2);
    check("t5_done_total", s_done_cnt, 1);
    check("t5_l_done_total", s_ldone_cnt, 0);
    check("both_gnt_never", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
